dijkstra_min_queue: RTL and testbench



---
 rtl/dijkstra_min_queue_if.sv | 29 ++
 rtl/dijkstra_min_queue.sv | 155 +++++++++++++++
 tb/tb_dijkstra_min_queue.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dijkstra_min_queue_if.sv
// Handshake bundle between dijkstra_min_queue and its two clients:
// the edge-relaxation engine (upd_*) and the path controller (pop_*/out_*).
// master = client side, slave = the queue itself.
interface dijkstra_min_queue_if #(
    parameter int INDEX_WIDTH = 3,
    parameter int VALUE_WIDTH = 8
);
    logic                   upd_valid;
    logic                   upd_ready;
    logic [INDEX_WIDTH-1:0] upd_index;
    logic [VALUE_WIDTH-1:0] upd_value;
    logic                   pop_valid;
    logic                   pop_ready;
    logic                   out_valid;
    logic [INDEX_WIDTH-1:0] out_index;
    logic [VALUE_WIDTH-1:0] out_value;
    logic                   out_empty;
    logic                   busy;

    modport master (
        output upd_valid, upd_index, upd_value, pop_valid,
        input  upd_ready, pop_ready, out_valid, out_index, out_value, out_empty, busy
    );

    modport slave (
        input  upd_valid, upd_index, upd_value, pop_valid,
        output upd_ready, pop_ready, out_valid, out_index, out_value, out_empty, busy
    );
endinterface

// File: rtl/dijkstra_min_queue.sv
// Indexed min-priority queue for the Dijkstra datapath.
// One distance word and one visited bit per node; relax = decrease-key
// (strictly smaller only), pop = sequential scan of LANES nodes per cycle
// followed by a one-cycle response that retires the winning node.
// Optional: define DIJKSTRA_MIN_QUEUE_REMAINING_EN to add the
// remaining / all_visited unvisited-node counter outputs.
module dijkstra_min_queue #(
    parameter int MAX_NODES   = 8,
    parameter int INDEX_WIDTH = 3,
    parameter int VALUE_WIDTH = 8,
    parameter int LANES       = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INDEX_WIDTH-1:0] src_index,
    dijkstra_min_queue_if.slave    q
`ifdef DIJKSTRA_MIN_QUEUE_REMAINING_EN
    ,
    output logic [INDEX_WIDTH:0]   remaining,
    output logic                   all_visited
`endif
);

    localparam logic [VALUE_WIDTH-1:0] INFINITY = '1;
    localparam logic [INDEX_WIDTH-1:0] STEP     = INDEX_WIDTH'(LANES);
    localparam logic [INDEX_WIDTH-1:0] LAST_PTR = INDEX_WIDTH'(MAX_NODES - LANES);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t                 state_q;
    logic [VALUE_WIDTH-1:0] dist_q [MAX_NODES];
    logic [MAX_NODES-1:0]   visited_q;
    logic [INDEX_WIDTH-1:0] ptr_q;
    logic [VALUE_WIDTH-1:0] best_val_q;
    logic [INDEX_WIDTH-1:0] best_idx_q;
    logic                   out_valid_q;
    logic [INDEX_WIDTH-1:0] out_index_q;
    logic [VALUE_WIDTH-1:0] out_value_q;
    logic                   out_empty_q;

    // Per-lane view of the group currently under the scan pointer.
    logic [INDEX_WIDTH-1:0] lane_idx  [LANES];
    logic [VALUE_WIDTH-1:0] lane_dist [LANES];
    logic [LANES-1:0]       lane_open;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_idx[gi]  = ptr_q + INDEX_WIDTH'(gi);
            assign lane_dist[gi] = dist_q[lane_idx[gi]];
            assign lane_open[gi] = !visited_q[lane_idx[gi]];
        end
    endgenerate

    logic [VALUE_WIDTH-1:0] scan_val;
    logic [INDEX_WIDTH-1:0] scan_idx;

    // Fold the lanes into the running best; lower lanes first and a strict
    // compare, so ties keep the lower index.
    always_comb begin
        scan_val = best_val_q;
        scan_idx = best_idx_q;
        for (int l = 0; l < LANES; l++) begin
            if (lane_open[l] && (lane_dist[l] < scan_val)) begin
                scan_val = lane_dist[l];
                scan_idx = lane_idx[l];
            end
        end
    end

    logic relax_take;
    assign relax_take = !visited_q[q.upd_index] && (q.upd_value < dist_q[q.upd_index]);

    // Main FSM: relax writes, pop scan, response strobe and node retirement.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            best_val_q  <= INFINITY;
            best_idx_q  <= '0;
            visited_q   <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_value_q <= '0;
            out_empty_q <= 1'b0;
            for (int i = 0; i < MAX_NODES; i++) begin
                dist_q[i] <= (INDEX_WIDTH'(i) == src_index) ? '0 : INFINITY;
            end
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (q.upd_valid && relax_take) begin
                        dist_q[q.upd_index] <= q.upd_value;
                    end
                    if (q.pop_valid && !q.upd_valid) begin
                        state_q    <= SCAN;
                        best_val_q <= INFINITY;
                        best_idx_q <= '0;
                        ptr_q      <= '0;
                    end
                end
                SCAN: begin
                    best_val_q <= scan_val;
                    best_idx_q <= scan_idx;
                    ptr_q      <= ptr_q + STEP;
                    if (ptr_q == LAST_PTR) begin
                        state_q     <= RESP;
                        out_valid_q <= 1'b1;
                        if (scan_val != INFINITY) begin
                            out_index_q <= scan_idx;
                            out_value_q <= scan_val;
                            out_empty_q <= 1'b0;
                        end else begin
                            out_index_q <= '0;
                            out_value_q <= INFINITY;
                            out_empty_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (!out_empty_q) begin
                        visited_q[best_idx_q] <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign q.upd_ready = (state_q == IDLE);
    assign q.pop_ready = (state_q == IDLE) && !q.upd_valid;
    assign q.out_valid = out_valid_q;
    assign q.out_index = out_index_q;
    assign q.out_value = out_value_q;
    assign q.out_empty = out_empty_q;
    assign q.busy      = (state_q != IDLE);

`ifdef DIJKSTRA_MIN_QUEUE_REMAINING_EN
    logic [INDEX_WIDTH:0] remaining_q;

    // Count unvisited nodes down once per successful extraction, saturating at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            remaining_q <= (INDEX_WIDTH+1)'(MAX_NODES);
        end else if ((state_q == RESP) && !out_empty_q && (remaining_q != '0)) begin
            remaining_q <= remaining_q - 1'b1;
        end
    end

    assign remaining   = remaining_q;
    assign all_visited = (remaining_q == '0);
`endif

endmodule

// File: tb/tb_dijkstra_min_queue.sv
// Self-checking bench for dijkstra_min_queue: expected pop results are pushed
// to a scoreboard at the pop handshake and compared (value and latency) when
// out_valid strobes. Define DIJKSTRA_MIN_QUEUE_REMAINING_EN to also check the counter.
module tb_dijkstra_min_queue;

    localparam int LAT = 8 / 2 + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] src_index = 3'd0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    dijkstra_min_queue_if #(.INDEX_WIDTH(3), .VALUE_WIDTH(8)) q_if ();

`ifdef DIJKSTRA_MIN_QUEUE_REMAINING_EN
    logic [3:0] remaining;
    logic       all_visited;
`endif

    dijkstra_min_queue #(
        .MAX_NODES(8), .INDEX_WIDTH(3), .VALUE_WIDTH(8), .LANES(2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .src_index  (src_index),
        .q          (q_if.slave)
`ifdef DIJKSTRA_MIN_QUEUE_REMAINING_EN
        ,
        .remaining  (remaining),
        .all_visited(all_visited)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic       empty;
        logic [2:0] idx;
        logic [7:0] val;
        int         due;
    } exp_t;

    exp_t sb[$];

    // Scoreboard monitor: every strobe must match the oldest outstanding pop.
    always @(negedge clock) begin
        exp_t e;
        if (q_if.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe got out_index=%0d out_value=%0d want no out_valid",
                         q_if.out_index, q_if.out_value);
            end else begin
                e = sb.pop_front();
                total++;
                if (q_if.out_empty !== e.empty) begin
                    bad++;
                    $display("FAIL out_empty got=%b want=%b", q_if.out_empty, e.empty);
                end
                total++;
                if (q_if.out_index !== e.idx) begin
                    bad++;
                    $display("FAIL out_index got=%0d want=%0d", q_if.out_index, e.idx);
                end
                total++;
                if (q_if.out_value !== e.val) begin
                    bad++;
                    $display("FAIL out_value got=%0d want=%0d", q_if.out_value, e.val);
                end
                total++;
                if (cyc !== e.due) begin
                    bad++;
                    $display("FAIL latency got_cycle=%0d want_cycle=%0d", cyc, e.due);
                end
                $display("pop result idx=%0d val=%0d empty=%b at cycle %0d",
                         q_if.out_index, q_if.out_value, q_if.out_empty, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset(input logic [2:0] src);
        @(negedge clock);
        reset       = 1'b1;
        src_index   = src;
        q_if.upd_valid = 1'b0;
        q_if.pop_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        $display("reset src_index=%0d", src);
    endtask

    // Drive one relax for one cycle; caller ends the burst with relax_end.
    task automatic relax(input logic [2:0] idx, input logic [7:0] val);
        @(negedge clock);
        q_if.upd_valid = 1'b1;
        q_if.upd_index = idx;
        q_if.upd_value = val;
        #1;
        total++;
        if (q_if.upd_ready !== 1'b1) begin
            bad++;
            $display("FAIL upd_ready got=%b want=1", q_if.upd_ready);
        end
        $display("relax idx=%0d val=%0d", idx, val);
    endtask

    task automatic relax_end();
        @(negedge clock);
        q_if.upd_valid = 1'b0;
    endtask

    task automatic pop_expect(input logic e_empty, input logic [2:0] e_idx, input logic [7:0] e_val);
        exp_t e;
        @(negedge clock);
        q_if.pop_valid = 1'b1;
        #1;
        total++;
        if (q_if.pop_ready !== 1'b1) begin
            bad++;
            $display("FAIL pop_ready got=%b want=1", q_if.pop_ready);
        end
        e.empty = e_empty;
        e.idx   = e_idx;
        e.val   = e_val;
        e.due   = cyc + LAT;
        sb.push_back(e);
        @(negedge clock);
        q_if.pop_valid = 1'b0;
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clock);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL pop_timeout got=no out_valid want=out_valid within %0d cycles", LAT);
            sb.delete();
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        do_reset(3'd3);
        total++;
        if (q_if.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", q_if.out_valid); end
        total++;
        if (q_if.out_index !== 3'd0) begin bad++; $display("FAIL rst_out_index got=%0d want=0", q_if.out_index); end
        total++;
        if (q_if.out_value !== 8'd0) begin bad++; $display("FAIL rst_out_value got=%0d want=0", q_if.out_value); end
        total++;
        if (q_if.out_empty !== 1'b0) begin bad++; $display("FAIL rst_out_empty got=%b want=0", q_if.out_empty); end
        total++;
        if (q_if.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", q_if.busy); end
        total++;
        if (q_if.upd_ready !== 1'b1) begin bad++; $display("FAIL rst_upd_ready got=%b want=1", q_if.upd_ready); end
        pop_expect(1'b0, 3'd3, 8'd0);
    endtask

    task automatic test_relax_order();
        relax(3'd5, 8'd20);
        relax(3'd1, 8'd9);
        relax(3'd5, 8'd30);
        relax_end();
        pop_expect(1'b0, 3'd1, 8'd9);
        pop_expect(1'b0, 3'd5, 8'd20);
    endtask

    task automatic test_tie_visited();
        relax(3'd2, 8'd7);
        relax(3'd6, 8'd7);
        relax_end();
        pop_expect(1'b0, 3'd2, 8'd7);
        relax(3'd2, 8'd1);
        relax_end();
        pop_expect(1'b0, 3'd6, 8'd7);
        pop_expect(1'b1, 3'd0, 8'd255);
    endtask

    task automatic test_empty_priority();
        do_reset(3'd0);
        pop_expect(1'b0, 3'd0, 8'd0);
        pop_expect(1'b1, 3'd0, 8'd255);
        total++;
        if (q_if.out_empty !== 1'b1 || q_if.out_value !== 8'd255 || q_if.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold got empty=%b value=%0d valid=%b want empty=1 value=255 valid=0",
                     q_if.out_empty, q_if.out_value, q_if.out_valid);
        end
        @(negedge clock);
        q_if.upd_valid = 1'b1;
        q_if.upd_index = 3'd4;
        q_if.upd_value = 8'd50;
        q_if.pop_valid = 1'b1;
        #1;
        total++;
        if (q_if.pop_ready !== 1'b0) begin bad++; $display("FAIL prio_pop_ready got=%b want=0", q_if.pop_ready); end
        total++;
        if (q_if.upd_ready !== 1'b1) begin bad++; $display("FAIL prio_upd_ready got=%b want=1", q_if.upd_ready); end
        @(negedge clock);
        q_if.upd_valid = 1'b0;
        q_if.pop_valid = 1'b0;
        total++;
        if (q_if.busy !== 1'b0) begin bad++; $display("FAIL prio_busy got=%b want=0", q_if.busy); end
        $display("simultaneous relax+pop: relax idx=4 val=50 taken");
        pop_expect(1'b0, 3'd4, 8'd50);
    endtask

    task automatic test_reset_abort();
        @(negedge clock);
        q_if.pop_valid = 1'b1;
        @(negedge clock);
        q_if.pop_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        total++;
        if (q_if.busy !== 1'b1) begin bad++; $display("FAIL abort_busy_scan got=%b want=1", q_if.busy); end
        reset     = 1'b1;
        src_index = 3'd7;
        @(negedge clock);
        reset = 1'b0;
        total++;
        if (q_if.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", q_if.busy); end
        total++;
        if (q_if.out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid got=%b want=0", q_if.out_valid); end
        repeat (8) @(negedge clock);
        $display("reset during scan, src_index=7");
        pop_expect(1'b0, 3'd7, 8'd0);
    endtask

    task automatic test_remaining();
`ifdef DIJKSTRA_MIN_QUEUE_REMAINING_EN
        do_reset(3'd0);
        total++;
        if (remaining !== 4'd8) begin bad++; $display("FAIL remaining_rst got=%0d want=8", remaining); end
        total++;
        if (all_visited !== 1'b0) begin bad++; $display("FAIL all_visited_rst got=%b want=0", all_visited); end
        pop_expect(1'b0, 3'd0, 8'd0);
        total++;
        if (remaining !== 4'd7) begin bad++; $display("FAIL remaining_one got=%0d want=7", remaining); end
        pop_expect(1'b1, 3'd0, 8'd255);
        total++;
        if (remaining !== 4'd7) begin bad++; $display("FAIL remaining_empty got=%0d want=7", remaining); end
        for (int i = 1; i < 8; i++) relax(3'(i), 8'(10 + i));
        relax_end();
        for (int i = 1; i < 8; i++) pop_expect(1'b0, 3'(i), 8'(10 + i));
        total++;
        if (remaining !== 4'd0) begin bad++; $display("FAIL remaining_all got=%0d want=0", remaining); end
        total++;
        if (all_visited !== 1'b1) begin bad++; $display("FAIL all_visited got=%b want=1", all_visited); end
        pop_expect(1'b1, 3'd0, 8'd255);
        total++;
        if (remaining !== 4'd0) begin bad++; $display("FAIL remaining_floor got=%0d want=0", remaining); end
`endif
    endtask

    initial begin
        q_if.upd_valid = 1'b0;
        q_if.upd_index = 3'd0;
        q_if.upd_value = 8'd0;
        q_if.pop_valid = 1'b0;
        test_reset();
        test_relax_order();
        test_tie_visited();
        test_empty_priority();
        test_reset_abort();
        test_remaining();
        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
